// File: rtl/osd_mam_arb_pkg.sv
// rtl/osd_mam_arb_pkg.sv - shared types and helpers for the MAM request arbiter
package osd_mam_arb_pkg;

  localparam int BEATS_W = 13;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WDATA = 2'd2,
    RDATA = 2'd3
  } state_t;

  function automatic int unsigned next_rr(input int unsigned ptr, input int unsigned nreq);
    return (ptr + 1 >= nreq) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/osd_rr_arbiter.sv
// rtl/osd_rr_arbiter.sv - combinational rotate-priority pick starting at ptr
module osd_rr_arbiter #(
  parameter int NREQ = 2,
  localparam int GW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [GW-1:0]   ptr,
  output logic            any,
  output logic [GW-1:0]   idx
);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic [GW:0]       sum;

  // rot[k] is the request at position (ptr + k) mod NREQ
  assign dbl = {req, req} >> ptr;
  assign rot = dbl[NREQ-1:0];

  always_comb begin
    any = 1'b0;
    sum = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        any = 1'b1;
        sum = {1'b0, ptr} + (GW+1)'(k);
      end
    end
    if (sum >= (GW+1)'(NREQ)) sum = sum - (GW+1)'(NREQ);
  end

  assign idx = sum[GW-1:0];

endmodule

// File: rtl/osd_mam_req_arbiter.sv
// rtl/osd_mam_req_arbiter.sv - round-robin sharing of one MAM access port,
// grant held for a whole transaction so bursts never interleave
module osd_mam_req_arbiter
  import osd_mam_arb_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 32,
  localparam int GW = $clog2(NREQ),
  localparam int SW = DATA_WIDTH / 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NREQ-1:0]              s_req_valid,
  output logic [NREQ-1:0]              s_req_ready,
  input  logic [NREQ-1:0]              s_req_we,
  input  logic [NREQ*ADDR_WIDTH-1:0]   s_req_addr,
  input  logic [NREQ-1:0]              s_req_burst,
  input  logic [NREQ*BEATS_W-1:0]      s_req_beats,
  input  logic [NREQ-1:0]              s_write_valid,
  input  logic [NREQ*DATA_WIDTH-1:0]   s_write_data,
  input  logic [NREQ*SW-1:0]           s_write_strb,
  output logic [NREQ-1:0]              s_write_ready,
  output logic [NREQ-1:0]              s_read_valid,
  output logic [DATA_WIDTH-1:0]        s_read_data,
  input  logic [NREQ-1:0]              s_read_ready,
  output logic                         m_req_valid,
  input  logic                         m_req_ready,
  output logic                         m_req_we,
  output logic [ADDR_WIDTH-1:0]        m_req_addr,
  output logic                         m_req_burst,
  output logic [BEATS_W-1:0]           m_req_beats,
  output logic                         m_write_valid,
  output logic [DATA_WIDTH-1:0]        m_write_data,
  output logic [SW-1:0]                m_write_strb,
  input  logic                         m_write_ready,
  input  logic                         m_read_valid,
  input  logic [DATA_WIDTH-1:0]        m_read_data,
  output logic                         m_read_ready,
  output logic                         gnt_valid,
  output logic [GW-1:0]                gnt_id
);

  state_t             state;
  logic [GW-1:0]      rr_ptr;
  logic [BEATS_W-1:0] beat_cnt;
  logic               arb_any;
  logic [GW-1:0]      arb_idx;

  logic [NREQ-1:0]    gnt_oh;
  logic               sel_req_valid, sel_wvalid, sel_rready;
  logic               data_hs;

  osd_rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req (s_req_valid),
    .ptr (rr_ptr),
    .any (arb_any),
    .idx (arb_idx)
  );

  always_comb begin
    gnt_oh        = '0;
    sel_req_valid = 1'b0;
    sel_wvalid    = 1'b0;
    sel_rready    = 1'b0;
    m_req_we      = 1'b0;
    m_req_addr    = '0;
    m_req_burst   = 1'b0;
    m_req_beats   = '0;
    m_write_data  = '0;
    m_write_strb  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_id == GW'(i)) begin
        gnt_oh[i]     = 1'b1;
        sel_req_valid = s_req_valid[i];
        sel_wvalid    = s_write_valid[i];
        sel_rready    = s_read_ready[i];
        m_req_we      = s_req_we[i];
        m_req_addr    = s_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        m_req_burst   = s_req_burst[i];
        m_req_beats   = s_req_beats[i*BEATS_W +: BEATS_W];
        m_write_data  = s_write_data[i*DATA_WIDTH +: DATA_WIDTH];
        m_write_strb  = s_write_strb[i*SW +: SW];
      end
    end
  end

  // Every handshake is qualified by state, so nothing leaks out in IDLE
  assign m_req_valid   = (state == REQ) && sel_req_valid;
  assign s_req_ready   = gnt_oh & {NREQ{(state == REQ) && m_req_ready}};
  assign m_write_valid = (state == WDATA) && sel_wvalid;
  assign s_write_ready = gnt_oh & {NREQ{(state == WDATA) && m_write_ready}};
  assign m_read_ready  = (state == RDATA) && sel_rready;
  assign s_read_valid  = gnt_oh & {NREQ{(state == RDATA) && m_read_valid}};
  assign s_read_data   = m_read_data;
  assign gnt_valid     = (state != IDLE);

  assign data_hs = (m_write_valid && m_write_ready) || (m_read_valid && m_read_ready);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      gnt_id   <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_any) begin
            gnt_id <= arb_idx;
            state  <= REQ;
          end
        end
        REQ: begin
          if (m_req_valid && m_req_ready) begin
            beat_cnt <= (m_req_burst && m_req_beats != '0) ? m_req_beats : BEATS_W'(1);
            state    <= m_req_we ? WDATA : RDATA;
          end
        end
        WDATA, RDATA: begin
          if (data_hs) begin
            if (beat_cnt != '0) beat_cnt <= beat_cnt - BEATS_W'(1);
            if (beat_cnt == BEATS_W'(1) || beat_cnt == '0) begin
              state  <= IDLE;
              rr_ptr <= GW'(next_rr(32'(gnt_id), NREQ));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_osd_mam_req_arbiter.sv
// tb/tb_osd_mam_req_arbiter.sv - directed self-checking bench for osd_mam_req_arbiter
module tb_osd_mam_req_arbiter;

  localparam int NREQ = 2;
  localparam int DW   = 16;
  localparam int AW   = 32;
  localparam int BW   = 13;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic [NREQ-1:0] s_req_valid = '0;
  logic [NREQ-1:0] s_req_ready;
  logic [NREQ-1:0] s_req_we = '0;
  logic [NREQ*AW-1:0] s_req_addr = '0;
  logic [NREQ-1:0] s_req_burst = '0;
  logic [NREQ*BW-1:0] s_req_beats = '0;
  logic [NREQ-1:0] s_write_valid = '0;
  logic [NREQ*DW-1:0] s_write_data = '0;
  logic [NREQ*DW/8-1:0] s_write_strb = '0;
  logic [NREQ-1:0] s_write_ready;
  logic [NREQ-1:0] s_read_valid;
  logic [DW-1:0]   s_read_data;
  logic [NREQ-1:0] s_read_ready = '0;
  logic            m_req_valid;
  logic            m_req_ready = 1'b1;
  logic            m_req_we;
  logic [AW-1:0]   m_req_addr;
  logic            m_req_burst;
  logic [BW-1:0]   m_req_beats;
  logic            m_write_valid;
  logic [DW-1:0]   m_write_data;
  logic [DW/8-1:0] m_write_strb;
  logic            m_write_ready = 1'b1;
  logic            m_read_valid = 1'b0;
  logic [DW-1:0]   m_read_data = '0;
  logic            m_read_ready;
  logic            gnt_valid;
  logic            gnt_id;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  osd_mam_req_arbiter #(.NREQ(NREQ), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_we(s_req_we),
    .s_req_addr(s_req_addr), .s_req_burst(s_req_burst), .s_req_beats(s_req_beats),
    .s_write_valid(s_write_valid), .s_write_data(s_write_data), .s_write_strb(s_write_strb),
    .s_write_ready(s_write_ready), .s_read_valid(s_read_valid), .s_read_data(s_read_data),
    .s_read_ready(s_read_ready),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_we(m_req_we),
    .m_req_addr(m_req_addr), .m_req_burst(m_req_burst), .m_req_beats(m_req_beats),
    .m_write_valid(m_write_valid), .m_write_data(m_write_data), .m_write_strb(m_write_strb),
    .m_write_ready(m_write_ready), .m_read_valid(m_read_valid), .m_read_data(m_read_data),
    .m_read_ready(m_read_ready), .gnt_valid(gnt_valid), .gnt_id(gnt_id)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Counts data handshakes until the grant drops, bounded to 20 cycles
  task automatic count_beats(input bit wr, output int cnt);
    int cyc;
    cnt = 0;
    cyc = 0;
    while (gnt_valid && cyc < 20) begin
      if (wr ? (m_write_valid && m_write_ready) : (m_read_valid && m_read_ready)) cnt++;
      @(posedge clk_i);
      #2;
      cyc++;
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (gnt_valid !== 1'b0) begin errors++; $display("FAIL reset_gnt_valid got %0h exp 0", gnt_valid); end
    checks++; if (gnt_id !== 1'b0) begin errors++; $display("FAIL reset_gnt_id got %0h exp 0", gnt_id); end
    checks++; if ({m_req_valid, m_write_valid, m_read_ready} !== 3'b000) begin errors++; $display("FAIL reset_m_valids got %b exp 000", {m_req_valid, m_write_valid, m_read_ready}); end
    checks++; if ({s_req_ready, s_write_ready, s_read_valid} !== 6'b0) begin errors++; $display("FAIL reset_s_readys got %b exp 000000", {s_req_ready, s_write_ready, s_read_valid}); end
  endtask

  task automatic test_single_write();
    int cnt;
    s_req_valid = 2'b01; s_req_we = 2'b01; s_req_burst = 2'b01;
    s_req_addr[31:0] = 32'h1000; s_req_beats[12:0] = 13'd4;
    s_write_valid = 2'b01; s_write_data[15:0] = 16'hA5A5; s_write_strb[1:0] = 2'b11;
    #1;
    checks++; if (m_req_valid !== 1'b0) begin errors++; $display("FAIL sw_no_same_cycle got %0h exp 0", m_req_valid); end
    tick();
    checks++; if (m_req_valid !== 1'b1) begin errors++; $display("FAIL sw_req_valid got %0h exp 1", m_req_valid); end
    checks++; if (gnt_id !== 1'b0 || gnt_valid !== 1'b1) begin errors++; $display("FAIL sw_gnt got id %0h valid %0h exp 0 1", gnt_id, gnt_valid); end
    checks++; if (m_req_addr !== 32'h1000 || m_req_beats !== 13'd4 || m_req_we !== 1'b1) begin errors++; $display("FAIL sw_req_fields got %h %0d %0h exp 1000 4 1", m_req_addr, m_req_beats, m_req_we); end
    checks++; if (s_req_ready !== 2'b01) begin errors++; $display("FAIL sw_s_req_ready got %b exp 01", s_req_ready); end
    tick();
    s_req_valid = 2'b00;
    #1;
    checks++; if (m_write_data !== 16'hA5A5 || s_write_ready !== 2'b01 || m_read_ready !== 1'b0) begin errors++; $display("FAIL sw_wdata got %h %b %0h exp a5a5 01 0", m_write_data, s_write_ready, m_read_ready); end
    count_beats(1'b1, cnt);
    checks++; if (cnt !== 4) begin errors++; $display("FAIL sw_beats got %0d exp 4", cnt); end
    checks++; if (gnt_valid !== 1'b0) begin errors++; $display("FAIL sw_idle got %0h exp 0", gnt_valid); end
    s_write_valid = 2'b00;
  endtask

  task automatic test_two_reads();
    do_reset();
    s_req_valid = 2'b11; s_req_we = 2'b00; s_req_burst = 2'b00;
    s_read_ready = 2'b11;
    tick();
    checks++; if (gnt_id !== 1'b0 || m_req_valid !== 1'b1) begin errors++; $display("FAIL tr_first_gnt got id %0h valid %0h exp 0 1", gnt_id, m_req_valid); end
    checks++; if (s_req_ready !== 2'b01) begin errors++; $display("FAIL tr_ready0 got %b exp 01", s_req_ready); end
    tick();
    s_req_valid = 2'b10; m_read_valid = 1'b1; m_read_data = 16'hBEEF;
    #1;
    checks++; if (s_read_valid !== 2'b01 || s_read_data !== 16'hBEEF) begin errors++; $display("FAIL tr_rvalid0 got %b %h exp 01 beef", s_read_valid, s_read_data); end
    checks++; if (m_req_valid !== 1'b0 || s_req_ready !== 2'b00) begin errors++; $display("FAIL tr_blocked1 got %0h %b exp 0 00", m_req_valid, s_req_ready); end
    tick();
    m_read_valid = 1'b0;
    #1;
    checks++; if (gnt_valid !== 1'b0) begin errors++; $display("FAIL tr_idle_between got %0h exp 0", gnt_valid); end
    tick();
    checks++; if (gnt_id !== 1'b1 || m_req_valid !== 1'b1) begin errors++; $display("FAIL tr_second_gnt got id %0h valid %0h exp 1 1", gnt_id, m_req_valid); end
    tick();
    s_req_valid = 2'b00; m_read_valid = 1'b1;
    #1;
    checks++; if (s_read_valid !== 2'b10) begin errors++; $display("FAIL tr_rvalid1 got %b exp 10", s_read_valid); end
    tick();
    m_read_valid = 1'b0;
  endtask

  task automatic test_fairness();
    int n;
    int cyc;
    bit drop;
    logic got [3];
    n = 0; cyc = 0;
    got[0] = 1'bx; got[1] = 1'bx; got[2] = 1'bx;
    s_req_valid = 2'b11; s_req_we = 2'b00; s_req_burst = 2'b00;
    s_read_ready = 2'b11; m_read_valid = 1'b1;
    #1;
    while (n < 3 && cyc < 40) begin
      drop = 1'b0;
      if (m_req_valid && m_req_ready) begin
        got[n] = gnt_id;
        n++;
        drop = (gnt_id == 1'b1);
      end
      tick();
      if (drop) s_req_valid[1] = 1'b0;
      cyc++;
    end
    s_req_valid = 2'b00;
    cyc = 0;
    while (gnt_valid && cyc < 10) begin tick(); cyc++; end
    m_read_valid = 1'b0;
    checks++; if (n !== 3) begin errors++; $display("FAIL fair_count got %0d exp 3", n); end
    checks++; if ({got[0], got[1], got[2]} !== 3'b010) begin errors++; $display("FAIL fair_order got %b%b%b exp 010", got[0], got[1], got[2]); end
    checks++; if (gnt_valid !== 1'b0) begin errors++; $display("FAIL fair_drain got %0h exp 0", gnt_valid); end
  endtask

  task automatic test_nonburst_write();
    int cnt;
    s_req_valid = 2'b01; s_req_we = 2'b01; s_req_burst = 2'b00; s_req_beats[12:0] = 13'd7;
    s_write_valid = 2'b01; s_write_strb[1:0] = 2'b01; s_write_data[15:0] = 16'h1234;
    tick();
    tick();
    s_req_valid = 2'b00;
    #1;
    checks++; if (m_write_valid !== 1'b1 || m_write_strb !== 2'b01 || m_write_data !== 16'h1234) begin errors++; $display("FAIL nb_fields got %0h %b %h exp 1 01 1234", m_write_valid, m_write_strb, m_write_data); end
    count_beats(1'b1, cnt);
    checks++; if (cnt !== 1) begin errors++; $display("FAIL nb_beats got %0d exp 1", cnt); end
    s_write_valid = 2'b00;
  endtask

  task automatic test_burst_zero_read();
    int cnt;
    s_req_valid = 2'b10; s_req_we = 2'b00; s_req_burst = 2'b10; s_req_beats[25:13] = 13'd0;
    s_read_ready = 2'b10;
    tick();
    checks++; if (gnt_id !== 1'b1 || m_req_burst !== 1'b1 || m_req_beats !== 13'd0) begin errors++; $display("FAIL bz_req got %0h %0h %0d exp 1 1 0", gnt_id, m_req_burst, m_req_beats); end
    tick();
    s_req_valid = 2'b00; m_read_valid = 1'b1;
    #1;
    count_beats(1'b0, cnt);
    checks++; if (cnt !== 1 || gnt_valid !== 1'b0) begin errors++; $display("FAIL bz_beats got %0d gnt %0h exp 1 0", cnt, gnt_valid); end
    m_read_valid = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    s_req_valid = 2'b01; s_req_we = 2'b01; s_req_burst = 2'b01; s_req_beats[12:0] = 13'd4;
    tick();
    tick();
    s_req_valid = 2'b00; s_write_valid = 2'b01;
    tick();
    checks++; if (gnt_valid !== 1'b1 || m_write_valid !== 1'b1) begin errors++; $display("FAIL rm_in_burst got %0h %0h exp 1 1", gnt_valid, m_write_valid); end
    rst_i = 1'b1;
    tick();
    checks++; if ({m_req_valid, m_write_valid, m_read_ready, s_req_ready, s_write_ready, s_read_valid} !== 9'b0) begin errors++; $display("FAIL rm_outputs got %b exp 0", {m_req_valid, m_write_valid, m_read_ready, s_req_ready, s_write_ready, s_read_valid}); end
    checks++; if (gnt_valid !== 1'b0 || gnt_id !== 1'b0) begin errors++; $display("FAIL rm_gnt got %0h %0h exp 0 0", gnt_valid, gnt_id); end
    rst_i = 1'b0; s_write_valid = 2'b00;
    s_req_valid = 2'b10; s_req_we = 2'b00; s_req_burst = 2'b00;
    tick();
    checks++; if (gnt_id !== 1'b1 || m_req_valid !== 1'b1) begin errors++; $display("FAIL rm_regrant got %0h %0h exp 1 1", gnt_id, m_req_valid); end
    tick();
    s_req_valid = 2'b00; m_read_valid = 1'b1; s_read_ready = 2'b10;
    tick();
    m_read_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_two_reads();
    test_fairness();
    test_nonburst_write();
    test_burst_zero_read();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
